// File: rtl/vend_pkg.sv
// Shared vending-machine definitions: coin codes, coin values, FSM state encoding.
// Latency: n/a (constants, types and a pure helper function only).
// Backpressure: n/a.
package vend_pkg;

  // Coin codes shared by the acceptor and dispenser paths
  localparam logic [1:0] COIN_1U   = 2'b00;
  localparam logic [1:0] COIN_2U   = 2'b01;
  localparam logic [1:0] COIN_NONE = 2'b11;

  // Face values in 1-unit coins
  localparam int COIN_VAL_1 = 1;
  localparam int COIN_VAL_2 = 2;

  // State encoding shared so both FSMs decode the same values
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CALC   = 3'd1,
    ST_SELECT = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_DONE   = 3'd4,
    ST_FAULT  = 3'd5
  } vend_state_e;

  // Value of a presented coin; anything that is not a 2-unit code pays 1 unit
  function automatic logic [1:0] coin_value(input logic [1:0] code);
    return (code == COIN_2U) ? 2'(COIN_VAL_2) : 2'(COIN_VAL_1);
  endfunction

endpackage

// File: rtl/change_dispenser_ack_timer.sv
// Clear/enable counter that flags when ACK_TIMEOUT-1 un-acked cycles have been counted.
// Latency: o_expire is decoded from the registered count, valid the cycle the count lands.
// Backpressure: none; the counter saturates at its expiry value while enabled.
module ack_timer #(
  parameter int ACK_TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACK_TIMEOUT - 1);

  logic [CNT_W-1:0] r_count;

  assign o_expire = (r_count == CNT_MAX);

  // Count enabled cycles; clear has priority, hold once the expiry value is reached
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && !o_expire) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Pays out change (credit - PRICE) one coin per coin_valid/coin_ack handshake.
// Latency: first coin presented two cycles after start; zero change or underpay ends one cycle after start.
// Backpressure: a coin is held until coin_ack; ACK_TIMEOUT cycles without ack aborts with fault.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int PRICE       = 3,
  parameter int CREDIT_W    = 3,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CREDIT_W-1:0] credit,
  input  logic                empty2,
  input  logic                empty1,
  input  logic                coin_ack,
  output logic                coin_valid,
  output logic [1:0]          coin_code,
  output logic                busy,
  output logic                done,
  output logic                fault,
  output logic [CREDIT_W-1:0] remaining
);

  localparam logic [CREDIT_W-1:0] PRICE_W = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] TWO_W   = CREDIT_W'(COIN_VAL_2);

  vend_state_e         r_state;
  vend_state_e         w_state_nxt;
  logic [CREDIT_W-1:0] r_credit;
  logic [CREDIT_W-1:0] w_credit_nxt;
  logic [CREDIT_W-1:0] r_remaining;
  logic [CREDIT_W-1:0] w_remaining_nxt;
  logic [1:0]          r_coin_code;
  logic [1:0]          w_code_nxt;
  logic [CREDIT_W-1:0] w_coin_val;
  logic                w_tmr_clr;
  logic                w_tmr_en;
  logic                w_tmr_expire;

  ack_timer #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_ack_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_tmr_clr),
    .i_en     (w_tmr_en),
    .o_expire (w_tmr_expire)
  );

  // Moore outputs; the code bus reads NONE whenever no coin is being presented
  assign coin_valid = (r_state == ST_ISSUE);
  assign coin_code  = (r_state == ST_ISSUE) ? r_coin_code : COIN_NONE;
  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_DONE);
  assign fault      = (r_state == ST_FAULT);
  assign remaining  = r_remaining;

  assign w_coin_val = CREDIT_W'(coin_value(r_coin_code));

  // Register state and the datapath it steers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_credit    <= '0;
      r_remaining <= '0;
      r_coin_code <= COIN_NONE;
    end else begin
      r_state     <= w_state_nxt;
      r_credit    <= w_credit_nxt;
      r_remaining <= w_remaining_nxt;
      r_coin_code <= w_code_nxt;
    end
  end

  // Next state, datapath updates and timer control
  always_comb begin
    w_state_nxt     = r_state;
    w_credit_nxt    = r_credit;
    w_remaining_nxt = r_remaining;
    w_code_nxt      = r_coin_code;
    w_tmr_clr       = 1'b0;
    w_tmr_en        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Owed change from an earlier fault is dropped only when a new sale starts
        if (start) begin
          w_credit_nxt    = credit;
          w_remaining_nxt = '0;
          w_state_nxt     = ST_CALC;
        end
      end
      ST_CALC: begin
        if (r_credit < PRICE_W) begin
          w_state_nxt = ST_FAULT;
        end else begin
          w_remaining_nxt = r_credit - PRICE_W;
          w_state_nxt     = (r_credit == PRICE_W) ? ST_DONE : ST_SELECT;
        end
      end
      ST_SELECT: begin
        // Prefer the larger coin; hopper-empty flags only matter here
        if ((r_remaining >= TWO_W) && !empty2) begin
          w_code_nxt  = COIN_2U;
          w_tmr_clr   = 1'b1;
          w_state_nxt = ST_ISSUE;
        end else if (!empty1) begin
          w_code_nxt  = COIN_1U;
          w_tmr_clr   = 1'b1;
          w_state_nxt = ST_ISSUE;
        end else begin
          w_state_nxt = ST_FAULT;
        end
      end
      ST_ISSUE: begin
        // An ack on the expiry cycle still counts as a paid coin
        if (coin_ack) begin
          w_remaining_nxt = r_remaining - w_coin_val;
          w_state_nxt     = (r_remaining == w_coin_val) ? ST_DONE : ST_SELECT;
        end else if (w_tmr_expire) begin
          w_state_nxt = ST_FAULT;
        end else begin
          w_tmr_en = 1'b1;
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      ST_FAULT: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

endmodule
